spimaster: RTL and testbench

- SPI mode 0 master with active-high chip select. It is the initiator matching the existing spislave.
- Accepts bytes over a valid/ready stream and serialises them MSB-first on mosi.
- Shifts in miso simultaneously and returns each received byte with a one-cycle strobe.
- Generates sck from the system clock; groups bytes into one CS-asserted transaction until a byte tagged last.

---
 rtl/spimaster.sv | 185 ++++++++++++++++++
 tb/tb_spimaster.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spimaster.sv
// SPI mode-0 master with active-high chip select. Streams bytes MSB-first on mosi and
// returns each byte shifted in from miso with a one-cycle rx_valid strobe.
module spimaster #(
  parameter int unsigned CLKDIV  = 4,
  parameter int unsigned CS_IDLE = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_last,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_busy,
  output logic       o_sck,
  output logic       o_mosi,
  input  logic       i_miso,
  output logic       o_cs
);

  localparam int unsigned CntMax = (CLKDIV > CS_IDLE) ? CLKDIV : CS_IDLE;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKDIV - 1);
  localparam logic [CntW-1:0] TailLast = CntW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StHigh,
    StLow,
    StWait,
    StTail
  } state_e;

  state_e          r_state, w_state;
  logic [CntW-1:0] r_cnt, w_cnt;
  logic [3:0]      r_bit_cnt, w_bit_cnt;
  logic [7:0]      r_tx_shift, w_tx_shift;
  logic [7:0]      r_rx_shift, w_rx_shift;
  logic            r_last, w_last;
  logic [7:0]      r_rx_data, w_rx_data;
  logic            r_rx_valid, w_rx_valid;
  logic            r_sck, w_sck;
  logic            r_mosi, w_mosi;
  logic            r_cs, w_cs;
  logic            r_miso_meta, r_miso_sync;
  logic            w_half_done;
  logic            w_accept;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_miso_meta <= 1'b0;
      r_miso_sync <= 1'b0;
    end else begin
      r_miso_meta <= i_miso;
      r_miso_sync <= r_miso_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_last     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs       <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_bit_cnt  <= w_bit_cnt;
      r_tx_shift <= w_tx_shift;
      r_rx_shift <= w_rx_shift;
      r_last     <= w_last;
      r_rx_data  <= w_rx_data;
      r_rx_valid <= w_rx_valid;
      r_sck      <= w_sck;
      r_mosi     <= w_mosi;
      r_cs       <= w_cs;
    end
  end

  assign w_half_done = (r_cnt == HalfLast);
  assign w_accept    = i_tx_valid && (r_state == StIdle || r_state == StWait);

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_bit_cnt  = r_bit_cnt;
    w_tx_shift = r_tx_shift;
    w_rx_shift = r_rx_shift;
    w_last     = r_last;
    w_rx_data  = r_rx_data;
    w_rx_valid = 1'b0;
    w_sck      = r_sck;
    w_mosi     = r_mosi;
    w_cs       = r_cs;

    unique case (r_state)
      StIdle, StWait: begin
        if (w_accept) begin
          w_tx_shift = i_tx_data;
          w_last     = i_tx_last;
          w_mosi     = i_tx_data[7];
          w_cs       = 1'b1;
          w_cnt      = '0;
          w_bit_cnt  = '0;
          w_state    = StLead;
        end
      end
      StLead: begin
        if (w_half_done) begin
          w_sck      = 1'b1;
          w_cnt      = '0;
          w_rx_shift = {r_rx_shift[6:0], r_miso_sync};
          w_state    = StHigh;
        end else begin
          w_cnt = r_cnt + CntW'(1);
        end
      end
      StHigh: begin
        if (w_half_done) begin
          w_sck     = 1'b0;
          w_cnt     = '0;
          w_bit_cnt = r_bit_cnt + 4'd1;
          w_state   = StLow;
          // The 8th sample already sits in the rx shift register; mosi holds after the byte.
          if (r_bit_cnt == 4'd7) begin
            w_rx_data  = r_rx_shift;
            w_rx_valid = 1'b1;
          end else begin
            w_tx_shift = {r_tx_shift[6:0], 1'b0};
            w_mosi     = r_tx_shift[6];
          end
        end else begin
          w_cnt = r_cnt + CntW'(1);
        end
      end
      StLow: begin
        if (w_half_done) begin
          w_cnt = '0;
          if (r_bit_cnt != 4'd8) begin
            w_sck      = 1'b1;
            w_rx_shift = {r_rx_shift[6:0], r_miso_sync};
            w_state    = StHigh;
          end else if (r_last) begin
            w_cs    = 1'b0;
            w_state = StTail;
          end else begin
            w_state = StWait;
          end
        end else begin
          w_cnt = r_cnt + CntW'(1);
        end
      end
      StTail: begin
        if (r_cnt == TailLast) begin
          w_cnt   = '0;
          w_state = StIdle;
        end else begin
          w_cnt = r_cnt + CntW'(1);
        end
      end
      default: begin
        w_state = StIdle;
      end
    endcase
  end

  // Gated by reset so the stream never sees a ready while the block is held.
  assign o_tx_ready = i_rst_n && (r_state == StIdle || r_state == StWait);
  assign o_busy     = (r_state != StIdle);
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_sck      = r_sck;
  assign o_mosi     = r_mosi;
  assign o_cs       = r_cs;

endmodule

// File: tb/tb_spimaster.sv
// Directed bench for spimaster: a mode-0 slave model on a CLKDIV=4 instance and a
// mosi->miso loopback on a CLKDIV=6, CS_IDLE=1 instance.
module tb_spimaster;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: CLKDIV=4, CS_IDLE=4
  logic [7:0] a_tx_data, a_rx_data;
  logic a_tx_last, a_tx_valid, a_tx_ready, a_rx_valid, a_busy, a_sck, a_mosi, a_cs;
  logic a_miso = 1'b0;

  spimaster #(.CLKDIV(4), .CS_IDLE(4)) u_dut_a (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_tx_data  (a_tx_data),
    .i_tx_last  (a_tx_last),
    .i_tx_valid (a_tx_valid),
    .o_tx_ready (a_tx_ready),
    .o_rx_data  (a_rx_data),
    .o_rx_valid (a_rx_valid),
    .o_busy     (a_busy),
    .o_sck      (a_sck),
    .o_mosi     (a_mosi),
    .i_miso     (a_miso),
    .o_cs       (a_cs)
  );

  // Instance B: CLKDIV=6, CS_IDLE=1, miso looped back from mosi
  logic [7:0] b_tx_data, b_rx_data;
  logic b_tx_last, b_tx_valid, b_tx_ready, b_rx_valid, b_busy, b_sck, b_mosi, b_cs;

  spimaster #(.CLKDIV(6), .CS_IDLE(1)) u_dut_b (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_tx_data  (b_tx_data),
    .i_tx_last  (b_tx_last),
    .i_tx_valid (b_tx_valid),
    .o_tx_ready (b_tx_ready),
    .o_rx_data  (b_rx_data),
    .o_rx_valid (b_rx_valid),
    .o_busy     (b_busy),
    .o_sck      (b_sck),
    .o_mosi     (b_mosi),
    .i_miso     (b_mosi),
    .o_cs       (b_cs)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model for A: loads reply on cs rise and after each 8th falling edge.
  logic [7:0] rep_q[$];
  logic [7:0] s_reply = 8'h00;
  int s_bit = 0;
  logic [7:0] m_shift = 8'h00;
  int m_bits = 0;
  logic [7:0] mosi_q[$];
  logic [7:0] rx_q[$];
  int cs_len_q[$];
  int cs_run = 0;
  logic a_prev_sck = 1'b0, a_prev_mosi = 1'b0;
  int a_viol = 0;

  always @(posedge a_cs) begin
    s_reply = (rep_q.size() != 0) ? rep_q.pop_front() : 8'h00;
    s_bit   = 0;
    m_bits  = 0;
    a_miso  = s_reply[7];
  end

  always @(negedge a_sck) begin
    if (a_cs) begin
      s_bit++;
      if (s_bit == 8) begin
        s_bit   = 0;
        s_reply = (rep_q.size() != 0) ? rep_q.pop_front() : 8'h00;
      end
      a_miso = s_reply[7 - s_bit];
    end
  end

  always @(posedge a_sck) begin
    m_shift = {m_shift[6:0], a_mosi};
    m_bits++;
    if (m_bits % 8 == 0) mosi_q.push_back(m_shift);
  end

  always @(negedge clk) begin
    if (a_rx_valid) rx_q.push_back(a_rx_data);
    if (a_cs) cs_run++;
    else if (cs_run != 0) begin
      cs_len_q.push_back(cs_run);
      cs_run = 0;
    end
    if (a_sck && a_prev_sck && (a_mosi !== a_prev_mosi)) a_viol++;
    a_prev_sck  = a_sck;
    a_prev_mosi = a_mosi;
  end

  // Monitors for B: sck run lengths while cs is high, rx bytes, mosi stability.
  int b_run = 0;
  int b_hi_min = 999, b_hi_max = 0, b_lo_min = 999, b_lo_max = 0, b_hi_cnt = 0;
  int b_cs_run = 0, b_cs_len = 0;
  int b_viol = 0;
  logic b_prev_sck = 1'b0, b_prev_mosi = 1'b0;
  logic [7:0] b_rx_q[$];

  always @(negedge clk) begin
    if (b_rx_valid) b_rx_q.push_back(b_rx_data);
    if (b_cs) begin
      b_cs_run++;
      if (b_sck == b_prev_sck) b_run++;
      else begin
        if (b_prev_sck) begin
          b_hi_cnt++;
          if (b_run < b_hi_min) b_hi_min = b_run;
          if (b_run > b_hi_max) b_hi_max = b_run;
        end else begin
          if (b_run < b_lo_min) b_lo_min = b_run;
          if (b_run > b_lo_max) b_lo_max = b_run;
        end
        b_run = 1;
      end
    end else begin
      b_run = 0;
      if (b_cs_run != 0) begin
        b_cs_len = b_cs_run;
        b_cs_run = 0;
      end
    end
    if (b_sck && b_prev_sck && (b_mosi !== b_prev_mosi)) b_viol++;
    b_prev_sck  = b_sck;
    b_prev_mosi = b_mosi;
  end

  // Called at a negedge; returns at the negedge just after the accepting posedge.
  task automatic send_a(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    a_tx_data  = d;
    a_tx_last  = l;
    a_tx_valid = 1'b1;
    while (!a_tx_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) check_eq("send_a_timeout", 32'(t), 32'd0);
    @(negedge clk);
  endtask

  // Waits for cs to drop, then counts cycles cs stays low before tx_ready returns.
  task automatic wait_done_a(output int tail);
    int t;
    t = 0;
    while (a_cs && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) check_eq("wait_cs_timeout", 32'(t), 32'd0);
    tail = 0;
    while (!a_tx_ready && tail < 100) begin
      @(negedge clk);
      tail++;
    end
  endtask

  task automatic clear_a();
    rep_q.delete();
    mosi_q.delete();
    rx_q.delete();
    cs_len_q.delete();
  endtask

  initial begin
    int tail, n, bad;
    rst_n      = 1'b0;
    a_tx_data  = 8'h00;
    a_tx_last  = 1'b0;
    a_tx_valid = 1'b0;
    b_tx_data  = 8'h00;
    b_tx_last  = 1'b0;
    b_tx_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_cs", a_cs, 1'b0);
    check_eq("rst_sck", a_sck, 1'b0);
    check_eq("rst_mosi", a_mosi, 1'b0);
    check_eq("rst_rx_data", a_rx_data, 8'h00);
    check_eq("rst_rx_valid", a_rx_valid, 1'b0);
    check_eq("rst_busy", a_busy, 1'b0);
    check_eq("rst_tx_ready", a_tx_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_tx_ready", a_tx_ready, 1'b1);

    // Single byte 0xA5, slave replies 0x3C
    clear_a();
    rep_q.push_back(8'h3C);
    send_a(8'hA5, 1'b1);
    a_tx_valid = 1'b0;
    check_eq("t1_busy", a_busy, 1'b1);
    wait_done_a(tail);
    check_eq("t1_mosi", (mosi_q.size() == 1) ? 32'(mosi_q[0]) : 32'hDEAD, 8'hA5);
    check_eq("t1_rx_count", rx_q.size(), 1);
    check_eq("t1_rx_data", (rx_q.size() != 0) ? 32'(rx_q[0]) : 32'hDEAD, 8'h3C);
    check_eq("t1_cs_len", (cs_len_q.size() != 0) ? 32'(cs_len_q[0]) : 32'hDEAD, 68);
    check_eq("t1_tail_ge4", (tail >= 4), 1'b1);

    // Burst 0x01,0x80,0xFF with tx_valid held, replies 0x11,0x22,0x33
    clear_a();
    rep_q.push_back(8'h11);
    rep_q.push_back(8'h22);
    rep_q.push_back(8'h33);
    send_a(8'h01, 1'b0);
    send_a(8'h80, 1'b0);
    send_a(8'hFF, 1'b1);
    // Keep offering a different byte through the last byte and TAIL
    a_tx_data = 8'h77;
    a_tx_last = 1'b1;
    wait_done_a(tail);
    a_tx_valid = 1'b0;
    check_eq("t2_tail", tail, 4);
    check_eq("t2_mosi_cnt", mosi_q.size(), 3);
    check_eq("t2_mosi0", (mosi_q.size() > 0) ? 32'(mosi_q[0]) : 32'hDEAD, 8'h01);
    check_eq("t2_mosi1", (mosi_q.size() > 1) ? 32'(mosi_q[1]) : 32'hDEAD, 8'h80);
    check_eq("t2_mosi2", (mosi_q.size() > 2) ? 32'(mosi_q[2]) : 32'hDEAD, 8'hFF);
    check_eq("t2_rx_cnt", rx_q.size(), 3);
    check_eq("t2_rx0", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD, 8'h11);
    check_eq("t2_rx1", (rx_q.size() > 1) ? 32'(rx_q[1]) : 32'hDEAD, 8'h22);
    check_eq("t2_rx2", (rx_q.size() > 2) ? 32'(rx_q[2]) : 32'hDEAD, 8'h33);
    check_eq("t2_cs_segments", cs_len_q.size(), 1);
    check_eq("t2_cs_len", (cs_len_q.size() != 0) ? 32'(cs_len_q[0]) : 32'hDEAD, 3 * 68 + 2);
    repeat (5) @(negedge clk);
    check_eq("t2_no_accept_in_tail", a_cs, 1'b0);

    // Two bytes with a 50-cycle gap in WAIT
    clear_a();
    rep_q.push_back(8'hC3);
    rep_q.push_back(8'h5A);
    send_a(8'h12, 1'b0);
    a_tx_valid = 1'b0;
    n = 0;
    while (!(a_tx_ready && a_cs) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("t3_reach_wait", (n < 1000), 1'b1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!a_cs || a_sck || !a_tx_ready) bad++;
    end
    check_eq("t3_wait_hold", bad, 0);
    send_a(8'h34, 1'b1);
    a_tx_valid = 1'b0;
    n = 0;
    while (!a_sck && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("t3_lead_len", n, 4);
    wait_done_a(tail);
    check_eq("t3_mosi", (mosi_q.size() == 2) ? {mosi_q[0], mosi_q[1]} : 32'hDEAD, 16'h1234);
    check_eq("t3_rx", (rx_q.size() == 2) ? {rx_q[0], rx_q[1]} : 32'hDEAD, 16'hC35A);

    // Reset during bit 4
    clear_a();
    rep_q.push_back(8'hA5);
    send_a(8'hFF, 1'b1);
    a_tx_valid = 1'b0;
    n = 0;
    while (m_bits < 4 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    #1 rst_n = 1'b0;
    #1;
    check_eq("t4_cs_async", a_cs, 1'b0);
    check_eq("t4_sck_async", a_sck, 1'b0);
    check_eq("t4_mosi_async", a_mosi, 1'b0);
    check_eq("t4_ready_in_rst", a_tx_ready, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("t4_no_rx_valid", rx_q.size(), 0);
    check_eq("t4_rx_data_clr", a_rx_data, 8'h00);
    clear_a();
    rep_q.push_back(8'h96);
    send_a(8'h5A, 1'b1);
    a_tx_valid = 1'b0;
    wait_done_a(tail);
    check_eq("t4_mosi", (mosi_q.size() == 1) ? 32'(mosi_q[0]) : 32'hDEAD, 8'h5A);
    check_eq("t4_rx", (rx_q.size() == 1) ? 32'(rx_q[0]) : 32'hDEAD, 8'h96);
    check_eq("a_mosi_stable", a_viol, 0);

    // Instance B: timing at CLKDIV=6, CS_IDLE=1, loopback data
    b_tx_data  = 8'hC6;
    b_tx_last  = 1'b1;
    b_tx_valid = 1'b1;
    n = 0;
    while (!b_tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    b_tx_valid = 1'b0;
    n = 0;
    while (b_cs && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tail = 0;
    while (!b_tx_ready && tail < 100) begin
      @(negedge clk);
      tail++;
    end
    check_eq("b_hi_min", b_hi_min, 6);
    check_eq("b_hi_max", b_hi_max, 6);
    check_eq("b_lo_min", b_lo_min, 6);
    check_eq("b_lo_max", b_lo_max, 6);
    check_eq("b_hi_count", b_hi_cnt, 8);
    check_eq("b_cs_len", b_cs_len, 17 * 6);
    check_eq("b_tail", tail, 1);
    check_eq("b_rx", (b_rx_q.size() == 1) ? 32'(b_rx_q[0]) : 32'hDEAD, 8'hC6);
    check_eq("b_mosi_stable", b_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
